// File: rtl/clock_pkg.sv
// Shared constants and types for the time-of-day counter.
package clock_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;

  localparam int unsigned SEC_MOD_DEF  = 60;
  localparam int unsigned MIN_MOD_DEF  = 60;
  localparam int unsigned HOUR_MOD_DEF = 24;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    StRun     = MODE_RUN,
    StSetHour = MODE_SET_HOUR,
    StSetMin  = MODE_SET_MIN
  } mode_e;

  function automatic logic rise(logic cur, logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/clock_time_counter_if.sv
// Button inputs and registered time/mode outputs of the clock counter.
interface clock_time_counter_if;
  import clock_pkg::*;

  logic             mode_btn;
  logic             inc_btn;
  logic [CNT_W-1:0] sec_bin;
  logic [CNT_W-1:0] min_bin;
  logic [CNT_W-1:0] hour_bin;
  logic [1:0]       mode;
  logic             sec_pulse;

  modport master (
    output mode_btn, inc_btn,
    input  sec_bin, min_bin, hour_bin, mode, sec_pulse
  );

  modport slave (
    input  mode_btn, inc_btn,
    output sec_bin, min_bin, hour_bin, mode, sec_pulse
  );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MOD counter with synchronous clear; wrap flags the MOD-1 -> 0 step.
module mod_counter #(
  parameter int unsigned MOD = 60,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic [W-1:0] q_d;

  assign wrap = en & (q == W'(MOD - 1));

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = wrap ? '0 : q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Binary hh:mm:ss counter with 1 Hz prescaler and RUN/SET_HOUR/SET_MIN setting FSM.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned SEC_MOD  = SEC_MOD_DEF,
  parameter int unsigned MIN_MOD  = MIN_MOD_DEF,
  parameter int unsigned HOUR_MOD = HOUR_MOD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_time_counter_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  mode_e            state_q, state_d;
  logic             mode_q, inc_q;
  logic             mode_edge, inc_edge;
  logic             in_run, in_set_hour, in_set_min;
  logic [PW-1:0]    presc_q, presc_d;
  logic             sec_pulse_q;
  logic             tick;
  logic             sec_clr, sec_en, min_en, hour_en;
  logic             sec_wrap, min_wrap, unused_hour_wrap;
  logic [CNT_W-1:0] sec_q, min_q, hour_q;

  // History resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b1;
      inc_q  <= 1'b1;
    end else begin
      mode_q <= bus.mode_btn;
      inc_q  <= bus.inc_btn;
    end
  end

  assign mode_edge = rise(bus.mode_btn, mode_q);
  assign inc_edge  = rise(bus.inc_btn, inc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      unique case (state_q)
        StRun:     state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        StSetMin:  state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    in_run      = 1'b0;
    in_set_hour = 1'b0;
    in_set_min  = 1'b0;
    unique case (state_q)
      StRun:     in_run      = 1'b1;
      StSetHour: in_set_hour = 1'b1;
      StSetMin:  in_set_min  = 1'b1;
      default:   in_run      = 1'b1;
    endcase
  end

  // Leaving RUN takes priority over a coincident tick: the time freezes and sec clears.
  assign tick = in_run & ~mode_edge & (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (!in_run || mode_edge || tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_pulse_q <= tick;
    end
  end

  assign sec_clr = in_run & mode_edge;
  assign sec_en  = tick;
  assign min_en  = in_run ? sec_wrap : (in_set_min & inc_edge & ~mode_edge);
  assign hour_en = in_run ? min_wrap : (in_set_hour & inc_edge & ~mode_edge);

  mod_counter #(.MOD(SEC_MOD), .W(CNT_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sec_clr),
    .en    (sec_en),
    .q     (sec_q),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(CNT_W)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (min_en),
    .q     (min_q),
    .wrap  (min_wrap)
  );

  mod_counter #(.MOD(HOUR_MOD), .W(CNT_W)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (1'b0),
    .en    (hour_en),
    .q     (hour_q),
    .wrap  (unused_hour_wrap)
  );

  assign bus.sec_bin   = sec_q;
  assign bus.min_bin   = min_q;
  assign bus.hour_bin  = hour_q;
  assign bus.mode      = state_q;
  assign bus.sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Self-checking bench: directed table, hand sequences and random stimulus vs a time-of-day model.
module tb_clock_time_counter;

  localparam int unsigned TICK = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clock_time_counter_if bus ();

  clock_time_counter #(.TICK_DIV(TICK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: time kept as seconds-of-day, cycles counted since last tick or RUN entry.
  int m_mode;
  int m_tod;
  int m_cyc;
  bit m_pm, m_pi, m_pulse;

  typedef struct {
    string name;
    bit    mb;
    bit    ib;
    int    presses;
    int    hold;
    int    e_sec, e_min, e_hour, e_mode;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_tod = 0; m_cyc = 0; m_pm = 1'b1; m_pi = 1'b1; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit mb, input bit ib);
    bit me, ie;
    int h, mi, s;
    me = mb && !m_pm;
    ie = ib && !m_pi;
    m_pm = mb; m_pi = ib; m_pulse = 1'b0;
    h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
    case (m_mode)
      0: begin
        if (me) begin
          m_mode = 1; m_tod = m_tod - s; m_cyc = 0;
        end else begin
          m_cyc++;
          if (m_cyc == TICK) begin
            m_cyc = 0; m_pulse = 1'b1; m_tod = (m_tod + 1) % 86400;
          end
        end
      end
      1: begin
        if (me) m_mode = 2;
        else if (ie) m_tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
      end
      default: begin
        if (me) begin
          m_mode = 0; m_cyc = 0;
        end else if (ie) begin
          m_tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    int exp_v, act_v;
    exp_v = ((((m_tod % 60) * 64 + (m_tod / 60) % 60) * 64 + m_tod / 3600) * 4 + m_mode) * 2
            + int'(m_pulse);
    act_v = (((int'(bus.sec_bin) * 64 + int'(bus.min_bin)) * 64 + int'(bus.hour_bin)) * 4
            + int'(bus.mode)) * 2 + int'(bus.sec_pulse);
    check("model {sec,min,hour,mode,pulse}", act_v, exp_v);
  endtask

  task automatic cyc(input bit mb, input bit ib);
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    @(posedge clk);
    model_step(mb, ib);
    #1;
    compare_model();
  endtask

  task automatic do_reset(input bit mb, input bit ib);
    bus.mode_btn = mb;
    bus.inc_btn  = ib;
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input string name, input bit mb, input bit ib, input int presses,
                         input int hold, input int es, input int em, input int eh, input int emd);
    vec_t v;
    v.name = name; v.mb = mb; v.ib = ib; v.presses = presses; v.hold = hold;
    v.e_sec = es; v.e_min = em; v.e_hour = eh; v.e_mode = emd;
    tbl.push_back(v);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int p = 0; p < tbl[i].presses; p++) begin
        for (int k = 0; k < tbl[i].hold; k++) cyc(tbl[i].mb, tbl[i].ib);
        cyc(1'b0, 1'b0);
      end
      check({tbl[i].name, " sec"},  int'(bus.sec_bin),  tbl[i].e_sec);
      check({tbl[i].name, " min"},  int'(bus.min_bin),  tbl[i].e_min);
      check({tbl[i].name, " hour"}, int'(bus.hour_bin), tbl[i].e_hour);
      check({tbl[i].name, " mode"}, int'(bus.mode),     tbl[i].e_mode);
    end
  endtask

  task automatic expect_first_pulse(input string name);
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0);
      pulses += int'(bus.sec_pulse);
    end
    check({name, " early pulses"}, pulses, 0);
    cyc(1'b0, 1'b0);
    check({name, " pulse on 4th cycle"}, int'(bus.sec_pulse), 1);
  endtask

  initial begin
    int pulses;
    bit rmb, rib;

    //       name               mb ib  n  hold sec min hour mode
    add_vec("enter set hour",   1, 0,  1, 1,   0,  0,  0,   1);
    add_vec("25 hour incs",     0, 1, 25, 1,   0,  0,  1,   1);
    add_vec("enter set min",    1, 0,  1, 1,   0,  0,  1,   2);
    add_vec("61 min incs",      0, 1, 61, 1,   0,  1,  1,   2);
    add_vec("held inc 50",      0, 1,  1, 50,  0,  2,  1,   2);
    add_vec("back to run",      1, 0,  1, 1,   0,  2,  1,   0);
    add_vec("set hour again",   1, 0,  1, 1,   0,  2,  1,   1);
    add_vec("4 hour incs",      0, 1,  4, 1,   0,  2,  5,   1);
    add_vec("simultaneous",     1, 1,  1, 1,   0,  2,  5,   2);
    add_vec("57 min incs",      0, 1, 57, 1,   0, 59,  5,   2);
    add_vec("run",              1, 0,  1, 1,   0, 59,  5,   0);
    add_vec("to set hour",      1, 0,  1, 1,   0, 59,  5,   1);
    add_vec("18 hour incs",     0, 1, 18, 1,   0, 59, 23,   1);
    add_vec("to set min",       1, 0,  1, 1,   0, 59, 23,   2);
    add_vec("to run 23:59",     1, 0,  1, 1,   0, 59, 23,   0);
    add_vec("set 12: hour",     1, 0,  1, 1,   0,  0,  0,   1);
    add_vec("12 hour incs",     0, 1, 12, 1,   0,  0, 12,   1);
    add_vec("set 34: min",      1, 0,  1, 1,   0,  0, 12,   2);
    add_vec("34 min incs",      0, 1, 34, 1,   0, 34, 12,   2);
    add_vec("run 12:34",        1, 0,  1, 1,   0, 34, 12,   0);

    rst_n = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset sec",   int'(bus.sec_bin),   0);
    check("reset min",   int'(bus.min_bin),   0);
    check("reset hour",  int'(bus.hour_bin),  0);
    check("reset mode",  int'(bus.mode),      0);
    check("reset pulse", int'(bus.sec_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    expect_first_pulse("after reset");
    repeat (36) cyc(1'b0, 1'b0);
    check("40 cycles sec",  int'(bus.sec_bin),  10);
    check("40 cycles min",  int'(bus.min_bin),  0);
    check("40 cycles hour", int'(bus.hour_bin), 0);
    check("40 cycles mode", int'(bus.mode),     0);
    repeat (108) cyc(1'b0, 1'b0);
    check("sec reaches 37", int'(bus.sec_bin), 37);

    run_table(0, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0);
      pulses += int'(bus.sec_pulse);
    end
    check("no pulse in set hour", pulses, 0);
    run_table(1, 14);

    // 23:59:00 in RUN, one cycle past entry: 235 cycles to 23:59:59, 4 more to rollover.
    repeat (235) cyc(1'b0, 1'b0);
    check("pre-roll sec",  int'(bus.sec_bin),  59);
    check("pre-roll min",  int'(bus.min_bin),  59);
    check("pre-roll hour", int'(bus.hour_bin), 23);
    expect_first_pulse("rollover");
    check("rollover sec",  int'(bus.sec_bin),  0);
    check("rollover min",  int'(bus.min_bin),  0);
    check("rollover hour", int'(bus.hour_bin), 0);

    run_table(15, 19);
    repeat (225) cyc(1'b0, 1'b0);
    check("12:34:56 sec",  int'(bus.sec_bin),  56);
    check("12:34:56 min",  int'(bus.min_bin),  34);
    check("12:34:56 hour", int'(bus.hour_bin), 12);
    rst_n = 1'b0;
    #2;
    check("mid reset sec",   int'(bus.sec_bin),   0);
    check("mid reset min",   int'(bus.min_bin),   0);
    check("mid reset hour",  int'(bus.hour_bin),  0);
    check("mid reset mode",  int'(bus.mode),      0);
    check("mid reset pulse", int'(bus.sec_pulse), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    expect_first_pulse("after mid reset");

    do_reset(1'b1, 1'b1);
    repeat (10) cyc(1'b1, 1'b1);
    check("held through reset mode", int'(bus.mode),     0);
    check("held through reset hour", int'(bus.hour_bin), 0);
    check("held through reset min",  int'(bus.min_bin),  0);
    repeat (2) cyc(1'b0, 1'b0);

    rmb = 1'b0;
    rib = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, (m_mode == 0) ? 199 : 9) == 0) rmb = ~rmb;
      if ($urandom_range(0, 1) == 0) rib = ~rib;
      if ($urandom_range(0, 999) == 0) do_reset(rmb, rib);
      else cyc(rmb, rib);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
